// File: rtl/systolic_pkg.sv
// Shared constants and output fitting for the 3x3 weight-stationary array.
// SATURATE_EN selects clamping instead of modulo truncation in fit().
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int KW     = 4;

  localparam int K_C22  = 4;
  localparam int K_C21  = 5;
  localparam int K_C12  = 8;
  localparam int K_C11  = 9;
  localparam int K_DONE = 10;

  function automatic logic [DATA_W-1:0] fit(
    input logic [ACC_W-1:0] s
  );
`ifdef SATURATE_EN
    if (|s[ACC_W-1:DATA_W]) fit = '1;
    else fit = s[DATA_W-1:0];
`else
    fit = s[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: stationary weight, registered activation
// hand-off to the right, combinational partial sum down the column.
// Ports: clk, rst, w, act_in, psum_in -> act_out, psum_out.
module systolic_pe
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] act_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] act_out,
  output logic [ACC_W-1:0]  psum_out
);

  logic [2*DATA_W-1:0] prod;

  assign prod     = w * act_in;
  assign psum_out = psum_in + ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) act_out <= '0;
    else     act_out <= act_in;
  end

endmodule

// File: rtl/systolic_3by3.sv
// 3x3 weight-stationary systolic MAC array computing a 2x2 valid
// convolution of a 4x4 image; one frame per reset.
// Ports: clk, rst (async high), B11..B33 weights, left1..3 lanes,
// C11..C22 captured window results, out = fitted column sum each cycle.
// SATURATE_EN: clamp results to 2^DATA_W-1 instead of truncating.
module systolic_3by3
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] B11,
  input  logic [DATA_W-1:0] B12,
  input  logic [DATA_W-1:0] B13,
  input  logic [DATA_W-1:0] B21,
  input  logic [DATA_W-1:0] B22,
  input  logic [DATA_W-1:0] B23,
  input  logic [DATA_W-1:0] B31,
  input  logic [DATA_W-1:0] B32,
  input  logic [DATA_W-1:0] B33,
  input  logic [DATA_W-1:0] left1,
  input  logic [DATA_W-1:0] left2,
  input  logic [DATA_W-1:0] left3,
  output logic [DATA_W-1:0] C11,
  output logic [DATA_W-1:0] C12,
  output logic [DATA_W-1:0] C21,
  output logic [DATA_W-1:0] C22,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] w [3][3];
  logic [DATA_W-1:0] act [3][3];
  logic [DATA_W-1:0] tail_unused [3];
  logic [ACC_W-1:0]  psum [4][3];

  logic [DATA_W-1:0] l1_q1, l1_q2, l2_q1;
  logic [KW-1:0]     k;
  logic [ACC_W-1:0]  s;
  logic [DATA_W-1:0] y;

  assign w[0][0] = B11;
  assign w[0][1] = B12;
  assign w[0][2] = B13;
  assign w[1][0] = B21;
  assign w[1][1] = B22;
  assign w[1][2] = B23;
  assign w[2][0] = B31;
  assign w[2][1] = B32;
  assign w[2][2] = B33;

  // Lane skew: row r enters (3-r) cycles late so all rows line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_q1 <= '0;
      l1_q2 <= '0;
      l2_q1 <= '0;
    end else begin
      l1_q1 <= left1;
      l1_q2 <= l1_q1;
      l2_q1 <= left2;
    end
  end

  assign act[0][0] = l1_q2;
  assign act[1][0] = l2_q1;
  assign act[2][0] = left3;

  genvar r, c;
  generate
    for (c = 0; c < 3; c++) begin : g_top
      assign psum[0][c] = '0;
    end
    for (r = 0; r < 3; r++) begin : g_row
      for (c = 0; c < 3; c++) begin : g_col
        if (c == 2) begin : g_last
          systolic_pe u_pe (
            .clk      (clk),
            .rst      (rst),
            .w        (w[r][c]),
            .act_in   (act[r][c]),
            .psum_in  (psum[r][c]),
            .act_out  (tail_unused[r]),
            .psum_out (psum[r+1][c])
          );
        end else begin : g_mid
          systolic_pe u_pe (
            .clk      (clk),
            .rst      (rst),
            .w        (w[r][c]),
            .act_in   (act[r][c]),
            .psum_in  (psum[r][c]),
            .act_out  (act[r][c+1]),
            .psum_out (psum[r+1][c])
          );
        end
      end
    end
  endgenerate

  assign s = psum[3][0] + psum[3][1] + psum[3][2];
  assign y = fit(s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k   <= '0;
      out <= '0;
      C11 <= '0;
      C12 <= '0;
      C21 <= '0;
      C22 <= '0;
    end else begin
      out <= y;
      if (k != KW'(K_DONE)) k <= k + 1'b1;
      if (k == KW'(K_C22)) C22 <= y;
      if (k == KW'(K_C21)) C21 <= y;
      if (k == KW'(K_C12)) C12 <= y;
      if (k == KW'(K_C11)) C11 <= y;
    end
  end

endmodule

// File: tb/tb_systolic_3by3.sv
// Directed bench for systolic_3by3 with a convolution-sum model
// and literal pins on the captured window results.
module tb_systolic_3by3;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] B11, B12, B13, B21, B22, B23, B31, B32, B33;
  logic [7:0] left1, left2, left3;
  logic [7:0] C11, C12, C21, C22, out;

  systolic_3by3 dut (
    .clk(clk), .rst(rst),
    .B11(B11), .B12(B12), .B13(B13),
    .B21(B21), .B22(B22), .B23(B23),
    .B31(B31), .B32(B32), .B33(B33),
    .left1(left1), .left2(left2), .left3(left3),
    .C11(C11), .C12(C12), .C21(C21), .C22(C22),
    .out(out)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  bit done = 1'b0;

  int L1[10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
  int L2[10] = '{0, 12, 11, 10, 9, 8, 7, 6, 5, 0};
  int L3[10] = '{0, 0, 16, 15, 14, 13, 12, 11, 10, 9};

  // Model: history of sampled lane values, sum from the formula.
  int xh [3][256];
  int n = 0;
  int e_out = 0, e11 = 0, e12 = 0, e21 = 0, e22 = 0;

  function automatic int wt(int r, int c);
    logic [7:0] v;
    case (r * 3 + c)
      0: v = B11; 1: v = B12; 2: v = B13;
      3: v = B21; 4: v = B22; 5: v = B23;
      6: v = B31; 7: v = B32; default: v = B33;
    endcase
    return int'(v);
  endfunction

  function automatic int xv(int r, int idx, int cur);
    if (idx < 0) return 0;
    if (idx == n) return cur;
    return xh[r][idx];
  endfunction

  function automatic int model_s(int c1, int c2, int c3);
    int s = 0;
    int cur;
    for (int r = 0; r < 3; r++) begin
      cur = (r == 0) ? c1 : (r == 1) ? c2 : c3;
      for (int c = 0; c < 3; c++)
        s += wt(r, c) * xv(r, n - (2 - r) - c, cur);
    end
    return s;
  endfunction

  function automatic int mfit(int s);
`ifdef SATURATE_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    int sv;
    if (rst) begin
      n <= 0;
      e_out <= 0;
      e11 <= 0; e12 <= 0; e21 <= 0; e22 <= 0;
    end else begin
      sv = mfit(model_s(int'(left1), int'(left2), int'(left3)));
      xh[0][n] <= int'(left1);
      xh[1][n] <= int'(left2);
      xh[2][n] <= int'(left3);
      e_out <= sv;
      if (n == 4) e22 <= sv;
      if (n == 5) e21 <= sv;
      if (n == 8) e12 <= sv;
      if (n == 9) e11 <= sv;
      if (n < 255) n <= n + 1;
    end
  end

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("out", int'(out), e_out);
      chk("C11", int'(C11), e11);
      chk("C12", int'(C12), e12);
      chk("C21", int'(C21), e21);
      chk("C22", int'(C22), e22);
    end
  end

  task automatic set_w(int a, int b, int c, int d, int e,
                       int f, int g, int h, int i);
    B11 = 8'(a); B12 = 8'(b); B13 = 8'(c);
    B21 = 8'(d); B22 = 8'(e); B23 = 8'(f);
    B31 = 8'(g); B32 = 8'(h); B33 = 8'(i);
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) begin
      left1 = 8'(L1[i]);
      left2 = 8'(L2[i]);
      left3 = 8'(L3[i]);
      @(posedge clk);
      #1;
    end
    left1 = '0; left2 = '0; left3 = '0;
  endtask

  task automatic idle(int cycles);
    left1 = '0; left2 = '0; left3 = '0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lits(string tag, int a11, int a12,
                      int a21, int a22);
    chk({tag, "_C11"}, int'(C11), a11);
    chk({tag, "_C12"}, int'(C12), a12);
    chk({tag, "_C21"}, int'(C21), a21);
    chk({tag, "_C22"}, int'(C22), a22);
    chk({tag, "_m11"}, e11, a11);
    chk({tag, "_m22"}, e22, a22);
  endtask

`ifdef SATURATE_EN
  localparam int F11 = 255, F12 = 255, F21 = 255, F22 = 255;
`else
  localparam int F11 = 92, F12 = 137, F21 = 16, F22 = 61;
`endif

  initial begin
    rst = 1'b1;
    left1 = '0; left2 = '0; left3 = '0;
    set_w(1, 2, 3, 4, 5, 6, 7, 8, 9);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", int'(out), 0);
    lits("rst", 0, 0, 0, 0);

    // Full kernel frame.
    rst = 1'b0;
    run(10);
    idle(4);
    lits("full", F11, F12, F21, F22);
    chk("flush_out", int'(out), 0);

    // Only B11 set: results are delayed lane-1 samples.
    rst = 1'b1;
    set_w(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(10);
    idle(4);
    lits("b11", 1, 2, 5, 6);
    idle(3);
    lits("b11_hold", 1, 2, 5, 6);
    chk("b11_out", int'(out), 0);

    // Reset mid-frame, then replay the full frame.
    rst = 1'b1;
    set_w(1, 2, 3, 4, 5, 6, 7, 8, 9);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(6);
    lits("pre_abort", 0, 0, F21, F22);
    rst = 1'b1;
    #1;
    lits("abort", 0, 0, 0, 0);
    chk("abort_out", int'(out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(10);
    idle(4);
    lits("replay", F11, F12, F21, F22);

    // Reset held across a whole frame.
    rst = 1'b1;
    run(10);
    idle(2);
    lits("held", 0, 0, 0, 0);
    chk("held_out", int'(out), 0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
